// File: rtl/leaf_stream_bridge.sv
// Multi-channel FIFO bridge between leaf_interface vld/ack ports and an HLS
// operator's ap_vld/ap_ack streams, with sticky start latch, flush and counters.

module leaf_stream_bridge_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_BITS  = 3,
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  rd_gate,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ack,
  output logic                  rd_vld,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_ack,
  output logic [COUNT_BITS-1:0] xfer_count
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS:0]   wr_ptr, rd_ptr;
  logic                 clr, full, empty, do_wr, do_rd;

  assign clr   = reset | flush;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

  // Handshake outputs depend only on pointer state and the clear inputs,
  // never on the peer's vld, so a full FIFO cannot write through on a pop.
  assign wr_ack  = ~full & ~clr;
  assign rd_vld  = ~empty & rd_gate & ~clr;
  assign rd_data = mem[rd_ptr[ADDR_BITS-1:0]];
  assign do_wr   = wr_vld & wr_ack;
  assign do_rd   = rd_vld & rd_ack;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      xfer_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
      if (do_rd) begin
        rd_ptr     <= rd_ptr + (ADDR_BITS+1)'(1);
        xfer_count <= xfer_count + COUNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_BITS-1:0]] <= wr_data;
  end
endmodule

module leaf_stream_bridge #(
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned NUM_IN_PORTS    = 2,
  parameter int unsigned NUM_OUT_PORTS   = 2,
  parameter int unsigned FIFO_DEPTH_BITS = 3,
  parameter int unsigned COUNT_BITS      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ap_start,
  input  logic                                  flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  if_dout,
  input  logic [NUM_IN_PORTS-1:0]               if_vld,
  output logic [NUM_IN_PORTS-1:0]               if_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  user_din,
  output logic [NUM_IN_PORTS-1:0]               user_vld,
  input  logic [NUM_IN_PORTS-1:0]               user_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] user_dout,
  input  logic [NUM_OUT_PORTS-1:0]              user_dout_vld,
  output logic [NUM_OUT_PORTS-1:0]              user_dout_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_din,
  output logic [NUM_OUT_PORTS-1:0]              if_din_vld,
  input  logic [NUM_OUT_PORTS-1:0]              if_din_ack,
  output logic                                  user_start,
  output logic [NUM_IN_PORTS*COUNT_BITS-1:0]    in_count,
  output logic [NUM_OUT_PORTS*COUNT_BITS-1:0]   out_count
);
  logic start_q;

  // Sticky: only reset clears the start latch, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset)         start_q <= 1'b0;
    else if (ap_start) start_q <= 1'b1;
  end

  assign user_start = start_q;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_stream_bridge_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .ADDR_BITS  (FIFO_DEPTH_BITS),
      .COUNT_BITS (COUNT_BITS)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .rd_gate    (start_q),
      .wr_vld     (if_vld[i]),
      .wr_data    (if_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_ack     (if_ack[i]),
      .rd_vld     (user_vld[i]),
      .rd_data    (user_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_ack     (user_ack[i]),
      .xfer_count (in_count[i*COUNT_BITS +: COUNT_BITS])
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    leaf_stream_bridge_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .ADDR_BITS  (FIFO_DEPTH_BITS),
      .COUNT_BITS (COUNT_BITS)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .rd_gate    (1'b1),
      .wr_vld     (user_dout_vld[j]),
      .wr_data    (user_dout[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_ack     (user_dout_ack[j]),
      .rd_vld     (if_din_vld[j]),
      .rd_data    (if_din[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_ack     (if_din_ack[j]),
      .xfer_count (out_count[j*COUNT_BITS +: COUNT_BITS])
    );
  end
endmodule
